// File: rtl/reg_file.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// reg_file
// General-purpose register file for the processor datapath.
// 2**ADDR_WIDTH registers of DATA_WIDTH bits, two combinational read ports and
// one synchronous write port. Register 0 is hardwired to zero.
//
// Ports:
//   clk           - system clock, all state updates on the rising edge
//   rst_n         - synchronous active-low reset, clears every register
//   readAddress0  - register index for read port 0
//   readAddress1  - register index for read port 1
//   writeAddress  - register index for the write port
//   writeData     - data written at the rising edge
//   writeEnable   - active-high write enable
//   readData0     - contents of register readAddress0 (combinational)
//   readData1     - contents of register readAddress1 (combinational)
// -----------------------------------------------------------------------------
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] readAddress0,
   input  logic [ADDR_WIDTH-1:0] readAddress1,
   input  logic [ADDR_WIDTH-1:0] writeAddress,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  writeEnable,
   output logic [DATA_WIDTH-1:0] readData0,
   output logic [DATA_WIDTH-1:0] readData1
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] w_read_data0;
   logic [DATA_WIDTH-1:0] w_read_data1;
   logic                  w_write_hit;

   // A write only lands when enabled and aimed at a real register (not r0).
   assign w_write_hit = writeEnable && (writeAddress != {ADDR_WIDTH{1'b0}});

   // Register array update: reset clears everything and wins over a write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (w_write_hit) begin
         r_regs[writeAddress] <= writeData;
      end
   end

   // Read port 0: address 0 forced to zero independent of array contents.
   always_comb begin
      w_read_data0 = {DATA_WIDTH{1'b0}};
      if (readAddress0 == {ADDR_WIDTH{1'b0}}) begin
         w_read_data0 = {DATA_WIDTH{1'b0}};
      end else begin
         w_read_data0 = r_regs[readAddress0];
      end
   end

   // Read port 1: same structure as port 0, fully independent.
   always_comb begin
      w_read_data1 = {DATA_WIDTH{1'b0}};
      if (readAddress1 == {ADDR_WIDTH{1'b0}}) begin
         w_read_data1 = {DATA_WIDTH{1'b0}};
      end else begin
         w_read_data1 = r_regs[readAddress1];
      end
   end

   assign readData0 = w_read_data0;
   assign readData1 = w_read_data1;

endmodule

// File: tb/tb_reg_file.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file. A reference array is updated at every
// clock edge from the driven stimulus; expected read values are pushed to a
// queue when read addresses are applied and popped when the outputs settle.
// -----------------------------------------------------------------------------
module tb_reg_file;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] readAddress0;
   logic [AW-1:0] readAddress1;
   logic [AW-1:0] writeAddress;
   logic [DW-1:0] writeData;
   logic          writeEnable;
   logic [DW-1:0] readData0;
   logic [DW-1:0] readData1;

   logic [DW-1:0] model [0:31];
   logic [DW-1:0] exp_q [$];

   int vectors_applied = 0;
   int miscompares     = 0;

   reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .readAddress0 (readAddress0),
      .readAddress1 (readAddress1),
      .writeAddress (writeAddress),
      .writeData    (writeData),
      .writeEnable  (writeEnable),
      .readData0    (readData0),
      .readData1    (readData1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_value(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
      vectors_applied++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, updating the reference array from the
   // stimulus present at that edge, then step just past the edge.
   task automatic tick();
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (writeEnable && writeAddress != 5'd0) begin
         model[writeAddress] = writeData;
      end
      @(posedge clk);
      #1;
   endtask

   // Apply both read addresses, queue expectations, let outputs settle, compare.
   task automatic read_check(input string tag, input logic [AW-1:0] a0,
                             input logic [AW-1:0] a1);
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
      readAddress0 = a0;
      readAddress1 = a1;
      exp_q.push_back((a0 == 5'd0) ? 32'h0 : model[a0]);
      exp_q.push_back((a1 == 5'd0) ? 32'h0 : model[a1]);
      #1;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      check_value({tag, "_p0"}, readData0, e0);
      check_value({tag, "_p1"}, readData1, e1);
   endtask

   initial begin
      logic [AW-1:0] ra;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      rst_n        = 1'b0;
      readAddress0 = 5'd0;
      readAddress1 = 5'd0;
      writeEnable  = 1'b1;
      writeAddress = 5'd16;
      writeData    = 32'hFFFF_FFFF;
      @(negedge clk);

      // Reset with a competing write to reg16: reset must win.
      tick();
      tick();
      for (int i = 0; i < 32; i++) begin
         ra = 5'(i);
         read_check("reset", ra, 5'(31 - i));
      end
      rst_n = 1'b1;

      // Basic write/read.
      writeEnable  = 1'b1;
      writeAddress = 5'd16;
      writeData    = 32'd1;
      tick();
      writeAddress = 5'd17;
      writeData    = 32'd3;
      tick();
      writeEnable  = 1'b0;
      read_check("basic", 5'd16, 5'd17);
      check_value("basic_r16_lit", readData0, 32'd1);
      check_value("basic_r17_lit", readData1, 32'd3);

      // Write disable: address/data activity without enable.
      writeAddress = 5'd16;
      writeData    = 32'd4;
      tick();
      writeAddress = 5'd17;
      writeData    = 32'd5;
      tick();
      tick();
      read_check("wr_disable", 5'd16, 5'd17);
      check_value("wr_disable_lit", readData0, 32'd1);

      // Register 0 ignores writes and always reads zero.
      writeEnable  = 1'b1;
      writeAddress = 5'd0;
      writeData    = 32'hDEAD_BEEF;
      read_check("r0_before", 5'd0, 5'd16);
      tick();
      writeEnable = 1'b0;
      read_check("r0_after", 5'd0, 5'd0);
      check_value("r0_after_lit", readData0, 32'h0);

      // Same register on both ports; no bypass before the edge.
      writeEnable  = 1'b1;
      writeAddress = 5'd31;
      writeData    = 32'h1234_5678;
      read_check("r31_before", 5'd31, 5'd31);
      check_value("r31_before_lit", readData0, 32'h0);
      tick();
      writeEnable = 1'b0;
      read_check("r31_after", 5'd31, 5'd31);
      check_value("r31_after_lit", readData1, 32'h1234_5678);

      // Sweep: reg i gets i*0x01010101, read back in both orderings.
      writeEnable = 1'b1;
      for (int i = 1; i < 32; i++) begin
         writeAddress = 5'(i);
         writeData    = i * 32'h0101_0101;
         tick();
      end
      writeEnable = 1'b0;
      for (int i = 0; i < 32; i++) begin
         read_check("sweep_fwd", 5'(i), 5'(31 - i));
         read_check("sweep_rev", 5'(31 - i), 5'(i));
      end
      read_check("sweep_lit", 5'd5, 5'd0);
      check_value("sweep_r5_lit", readData0, 32'h0505_0505);

      // Randomised writes/reads, including no-op enables and r0 targets.
      for (int k = 0; k < 200; k++) begin
         writeEnable  = 1'($urandom_range(0, 1));
         writeAddress = 5'($urandom_range(0, 31));
         writeData    = $urandom;
         read_check("rand_pre", 5'($urandom_range(0, 31)), writeAddress);
         tick();
         read_check("rand_post", writeAddress, 5'($urandom_range(0, 31)));
      end
      writeEnable = 1'b0;

      // Reset again after traffic: everything clears.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         read_check("reset2", 5'(i), 5'(i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
